// File: rtl/port_uart_tx_pkg.sv
// port_uart_tx_pkg
//   Shared types and constants for the CPU port UART blocks.
//   uartTxState_t  : transmit FSM states
//   STATUS_*_BIT   : bit positions inside the status word returned to the CPU
//   counterWidth() : width for a counter that holds 0..n-1 (at least 1 bit)
package port_uart_tx_pkg;

    typedef enum logic [1:0] {
        UART_TX_IDLE,
        UART_TX_START,
        UART_TX_DATA,
        UART_TX_STOP
    } uartTxState_t;

    localparam int STATUS_ACK_BIT   = 31;
    localparam int STATUS_FULL_BIT  = 30;
    localparam int STATUS_EMPTY_BIT = 29;
    localparam int STATUS_BUSY_BIT  = 28;
    localparam int STATUS_COUNT_W   = 28;

    function automatic int counterWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/port_byte_fifo.sv
// port_byte_fifo
//   Circular byte FIFO of 2**DEPTH_LOG2 entries with a combinational read port.
//   Ports:
//     clock, reset        : core clock, async active-low reset
//     push, pushData      : write request and byte (ignored when full unless popping)
//     pop                 : read request (ignored when empty; no bypass)
//     popData             : byte at the head, valid while !empty
//     full, empty, count  : occupancy flags and count (0..DEPTH)
module port_byte_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            pushData,
    input  logic                  pop,
    output logic [7:0]            popData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  doPush;
    logic                  doPop;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/port_uart_tx.sv
// port_uart_tx
//   Peripheral end of a CPU memory-mapped port pair: bytes written by the CPU
//   are queued in a small FIFO and sent as UART 8N1 on txd.
//   Ports:
//     clock      : core clock
//     reset      : async active-low reset
//     cmdWord    : [31] cmdToggle, [7:0] data byte, rest ignored
//     statusWord : [31] ackToggle, [30] full, [29] empty, [28] busy, [27:0] count
//     txd        : serial output, idle high, registered
module port_uart_tx
    import port_uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cmdWord,
    output logic [31:0] statusWord,
    output logic        txd
);

    localparam int BAUD_W = counterWidth(CLOCKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

    uartTxState_t            state, stateNext;
    logic [BAUD_W-1:0]       baudCnt, baudNext;
    logic [2:0]              bitCnt, bitNext;
    logic [7:0]              shiftReg, shiftNext;
    logic                    txdNext;
    logic                    baudDone;

    logic                    ackToggle;
    logic                    cmdPending;
    logic                    push;
    logic                    pop;
    logic [7:0]              fifoData;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [FIFO_DEPTH_LOG2:0] fifoCount;
    logic                    unusedCmdBits;

    assign unusedCmdBits = ^cmdWord[30:8];

    // A command is outstanding until the ack toggle catches up with the CPU's toggle.
    assign cmdPending = (cmdWord[31] != ackToggle);
    assign push       = cmdPending && (!fifoFull || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ackToggle <= 1'b0;
        else if (push) ackToggle <= cmdWord[31];
    end

    port_byte_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pushData (cmdWord[7:0]),
        .pop      (pop),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= UART_TX_IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitCnt   <= bitNext;
            shiftReg <= shiftNext;
            txd      <= txdNext;
        end
    end

    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitCnt;
        shiftNext = shiftReg;
        pop       = 1'b0;
        baudDone  = (baudCnt == BAUD_LAST);
        case (state)
            UART_TX_IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shiftNext = fifoData;
                    baudNext  = '0;
                    stateNext = UART_TX_START;
                end
            end
            UART_TX_START: begin
                if (baudDone) begin
                    baudNext  = '0;
                    bitNext   = '0;
                    stateNext = UART_TX_DATA;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            UART_TX_DATA: begin
                if (baudDone) begin
                    baudNext = '0;
                    if (bitCnt == 3'd7) begin
                        stateNext = UART_TX_STOP;
                    end else begin
                        bitNext   = bitCnt + 1'b1;
                        shiftNext = {1'b0, shiftReg[7:1]};
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            UART_TX_STOP: begin
                if (baudDone) begin
                    baudNext = '0;
                    // Chain straight into the next start bit so queued frames have no idle gap.
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        shiftNext = fifoData;
                        stateNext = UART_TX_START;
                    end else begin
                        stateNext = UART_TX_IDLE;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            default: stateNext = UART_TX_IDLE;
        endcase

        // txd is registered from the next state so the line changes on the
        // same edge the FSM does.
        case (stateNext)
            UART_TX_START: txdNext = 1'b0;
            UART_TX_DATA:  txdNext = shiftNext[0];
            default:       txdNext = 1'b1;
        endcase
    end

    always_comb begin
        statusWord                   = '0;
        statusWord[STATUS_ACK_BIT]   = ackToggle;
        statusWord[STATUS_FULL_BIT]  = fifoFull;
        statusWord[STATUS_EMPTY_BIT] = fifoEmpty;
        statusWord[STATUS_BUSY_BIT]  = (state != UART_TX_IDLE);
        statusWord[STATUS_COUNT_W-1:0] = STATUS_COUNT_W'(fifoCount);
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx
//   Self-checking bench for port_uart_tx with CLOCKS_PER_BIT=4, depth 4.
//   A line decoder recovers bytes from txd; tasks compare against queues of
//   bytes written and against the protocol timing.
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cmdWord = '0;
    logic [31:0] statusWord;
    logic        txd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic curTog = 1'b0;

    logic [7:0] rxQ[$];
    int         startQ[$];
    int         frameErrs = 0;
    bit         monActive = 0;
    int         monCnt = 0;
    logic [7:0] monByte = '0;

    port_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmdWord    (cmdWord),
        .statusWord (statusWord),
        .txd        (txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line decoder: start detected on a low level while idle, each bit sampled mid-cell.
    always @(negedge clock) begin
        if (!reset) begin
            monActive = 0;
        end else if (!monActive) begin
            if (txd === 1'b0) begin
                monActive = 1;
                monCnt = 0;
                startQ.push_back(cyc);
            end
        end else begin
            monCnt++;
            if (monCnt == CPB/2 && txd !== 1'b0) frameErrs++;
            if (monCnt >= CPB + CPB/2 && monCnt < 9*CPB && ((monCnt - CPB - CPB/2) % CPB) == 0)
                monByte[(monCnt - CPB - CPB/2) / CPB] = txd;
            if (monCnt == 9*CPB + CPB/2) begin
                if (txd !== 1'b1) frameErrs++;
                rxQ.push_back(monByte);
                monActive = 0;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic writeByte(input logic [7:0] d);
        nextCycle();
        curTog = ~curTog;
        cmdWord = {curTog, 23'h0, d};
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        cmdWord = '0;
        curTog = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (statusWord !== 32'h2000_0000)
            $display("FAIL reset_status got=%h want=20000000", statusWord);
        checks++;
        if (txd !== 1'b1) $display("FAIL reset_txd got=%b want=1", txd);
        errors += (statusWord !== 32'h2000_0000) + (txd !== 1'b1);
        nextCycle();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (statusWord !== 32'h2000_0000 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_reset bad_cycles=%0d want=0 status=%h", bad, statusWord);
        end
    endtask

    task automatic test_single(input logic [7:0] d);
        logic [9:0] fr;
        int bad;
        int firstBad;
        fr = {1'b1, d, 1'b0};
        rxQ.delete();
        startQ.delete();
        frameErrs = 0;
        writeByte(d);
        @(negedge clock);
        bad = 0;
        firstBad = -1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clock);
            if (k == 1) begin
                checks++;
                if (statusWord[31] !== curTog || statusWord[27:0] !== 28'd1) begin
                    errors++;
                    $display("FAIL single_ack status=%h want ack=%b count=1", statusWord, curTog);
                end
            end
            if (k >= 2 && k <= 41 && txd !== fr[(k-2)/CPB]) begin
                bad++;
                if (firstBad < 0) firstBad = k;
            end
            if (k == 41) begin
                checks++;
                if (statusWord[28] !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy_end got=%b want=1", statusWord[28]);
                end
            end
            if (k == 42) begin
                checks++;
                if (statusWord !== {curTog, 3'b010, 28'd0}) begin
                    errors++;
                    $display("FAIL single_done status=%h want=%h", statusWord, {curTog, 3'b010, 28'd0});
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_wave data=%h bad_cycles=%0d first_at_N+%0d", d, bad, firstBad);
        end
        checks++;
        if (rxQ.size() != 1 || rxQ[0] !== d || frameErrs != 0) begin
            errors++;
            $display("FAIL single_rx got_n=%0d got=%h want=%h framing=%0d", rxQ.size(),
                     (rxQ.size() > 0) ? rxQ[0] : 8'h00, d, frameErrs);
        end
    endtask

    task automatic test_same_toggle();
        int bad;
        rxQ.delete();
        nextCycle();
        cmdWord = {curTog, 23'h0, 8'hFF};
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (statusWord[27:0] !== 28'd0 || statusWord[28] !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || rxQ.size() != 0) begin
            errors++;
            $display("FAIL same_toggle bad_cycles=%0d frames=%0d want 0/0", bad, rxQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expQ[$];
        logic [7:0] d;
        int waited;
        int held;
        bit ok;
        rxQ.delete();
        startQ.delete();
        frameErrs = 0;
        d = 8'($urandom);
        writeByte(d);
        expQ.push_back(d);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!(statusWord[28] === 1'b1 && statusWord[27:0] === 28'd0) && waited < 10);
        checks++;
        if (waited >= 10) begin
            errors++;
            $display("FAIL b2b_first_start timeout status=%h", statusWord);
        end
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            writeByte(d);
            expQ.push_back(d);
        end
        @(negedge clock);
        checks++;
        if (statusWord[30] !== 1'b1 || statusWord[27:0] !== 28'd4 || statusWord[31] === curTog) begin
            errors++;
            $display("FAIL b2b_full status=%h want full=1 count=4 ack!=%b", statusWord, curTog);
        end
        waited = 0;
        held = 0;
        while (statusWord[31] !== curTog && waited < 2*FRAME) begin
            @(negedge clock);
            waited++;
            if (statusWord[27:0] !== 28'd4 || statusWord[30] !== 1'b1) held++;
        end
        checks++;
        if (statusWord[31] !== curTog || held != 0 || waited < 2) begin
            errors++;
            $display("FAIL b2b_fifth_ack status=%h waited=%0d notfull_cycles=%0d", statusWord, waited, held);
        end
        @(negedge clock);
        checks++;
        if (txd !== 1'b0 || statusWord[28] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_chain txd=%b busy=%b want 0/1", txd, statusWord[28]);
        end
        waited = 0;
        while (statusWord[28] !== 1'b0 && waited < 7*FRAME) begin
            @(negedge clock);
            waited++;
        end
        repeat (2) @(negedge clock);
        ok = (rxQ.size() == expQ.size()) && (frameErrs == 0);
        if (ok) foreach (expQ[i]) if (rxQ[i] !== expQ[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_order frames=%0d want=%0d framing=%0d", rxQ.size(), expQ.size(), frameErrs);
        end
        ok = (startQ.size() == 6);
        if (ok) for (int i = 1; i < 6; i++) if (startQ[i] - startQ[i-1] != FRAME) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_gap starts=%0d want 6 with spacing %0d", startQ.size(), FRAME);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom) & 8'hF7;
        writeByte(d);
        writeByte(8'($urandom));
        @(negedge clock);
        repeat (18) @(negedge clock);
        checks++;
        if (txd !== 1'b0 || statusWord[28] !== 1'b1) begin
            errors++;
            $display("FAIL mid_before txd=%b busy=%b want 0/1", txd, statusWord[28]);
        end
        #1;
        reset = 1'b0;
        cmdWord = '0;
        curTog = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || statusWord !== 32'h2000_0000) begin
            errors++;
            $display("FAIL mid_reset txd=%b status=%h want 1/20000000", txd, statusWord);
        end
        repeat (2) @(posedge clock);
        nextCycle();
        reset = 1'b1;
        repeat (5) @(negedge clock);
        test_single(8'h0F);
    endtask

    task automatic test_random();
        logic [7:0] expQ[$];
        logic [7:0] d;
        int waited;
        bit ok;
        rxQ.delete();
        frameErrs = 0;
        for (int n = 0; n < 12; n++) begin
            waited = 0;
            while (statusWord[31] !== curTog && waited < 2*FRAME) begin
                @(negedge clock);
                waited++;
            end
            checks++;
            if (statusWord[31] !== curTog) begin
                errors++;
                $display("FAIL rand_ack n=%0d status=%h want ack=%b", n, statusWord, curTog);
            end
            repeat ($urandom_range(0, 3)) @(posedge clock);
            d = 8'($urandom);
            writeByte(d);
            expQ.push_back(d);
        end
        waited = 0;
        while ((rxQ.size() < expQ.size() || statusWord[28] !== 1'b0) && waited < 20*FRAME) begin
            @(negedge clock);
            waited++;
        end
        ok = (rxQ.size() == expQ.size()) && (frameErrs == 0);
        if (ok) foreach (expQ[i]) if (rxQ[i] !== expQ[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rand_stream frames=%0d want=%0d framing=%0d", rxQ.size(), expQ.size(), frameErrs);
        end
        checks++;
        if (statusWord !== {curTog, 3'b010, 28'd0}) begin
            errors++;
            $display("FAIL rand_final status=%h want=%h", statusWord, {curTog, 3'b010, 28'd0});
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_same_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
